risc_ctrl_path: RTL and testbench

RISC_CTRL_PATH -- requirements
Module: risc_ctrl_path

---
 rtl/risc_pkg.sv | 36 +++
 rtl/risc_ctrl_path_if.sv | 37 +++
 rtl/risc_phase_seq.sv | 125 ++++++++++++
 rtl/risc_ctrl_path.sv | 55 +++++
 tb/tb_risc_ctrl_path.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared types and width defaults for the RISC control path.
package risc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned OPC_W      = 3;
  localparam int unsigned PH_W       = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PH_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes that read memory and write the accumulator.
  function automatic logic is_aluop(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl_path_if.sv
// Bundle of datapath operands, results and control strobes for risc_ctrl_path.
interface risc_ctrl_path_if
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] accum;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] op_addr;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] alu_out;
  logic              is_zero;
  logic              sel;
  logic              rd;
  logic              ld_ir;
  logic              halt;
  logic              inc_pc;
  logic              ld_ac;
  logic              ld_pc;
  logic              wr;
  logic              data_e;

  modport master (
    output opcode, accum, data_in, pc_addr, op_addr,
    input  addr_out, alu_out, is_zero,
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );

  modport slave (
    input  opcode, accum, data_in, pc_addr, op_addr,
    output addr_out, alu_out, is_zero,
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );
endinterface

// File: rtl/risc_phase_seq.sv
// 8-phase instruction sequencer with decoded control strobes.
// Optional macro HALT_LATCH_EN: HLT freezes the sequencer in OP_ADDR until reset.
module risc_phase_seq
  import risc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_is_zero,
  output logic             o_sel_c,
  output logic             o_rd_c,
  output logic             o_ld_ir_c,
  output logic             o_halt_c,
  output logic             o_inc_pc_c,
  output logic             o_ld_ac_c,
  output logic             o_ld_pc_c,
  output logic             o_wr_c,
  output logic             o_data_e_c
);

  localparam logic [PH_W-1:0] S_INST_ADDR  = PH_INST_ADDR;
  localparam logic [PH_W-1:0] S_INST_FETCH = PH_INST_FETCH;
  localparam logic [PH_W-1:0] S_INST_LOAD  = PH_INST_LOAD;
  localparam logic [PH_W-1:0] S_IDLE       = PH_IDLE;
  localparam logic [PH_W-1:0] S_OP_ADDR    = PH_OP_ADDR;
  localparam logic [PH_W-1:0] S_OP_FETCH   = PH_OP_FETCH;
  localparam logic [PH_W-1:0] S_ALU_OP     = PH_ALU_OP;
  localparam logic [PH_W-1:0] S_STORE      = PH_STORE;

  logic [PH_W-1:0] r_state;
  logic [PH_W-1:0] w_state_nxt;
  logic            w_aluop;
  logic            w_hlt;
  logic            w_skip;
  logic            w_jmp;
  logic            w_sto;

  assign w_aluop = is_aluop(i_opcode);
  assign w_hlt   = (i_opcode == OP_HLT);
  assign w_skip  = (i_opcode == OP_SKZ) && i_is_zero;
  assign w_jmp   = (i_opcode == OP_JMP);
  assign w_sto   = (i_opcode == OP_STO);

`ifdef HALT_LATCH_EN
  logic r_halted;
  logic w_halted_nxt;

  // State register plus sticky halt flag; reset overrides both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= w_halted_nxt;
    end
  end
`else
  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INST_ADDR;
    else     r_state <= w_state_nxt;
  end
`endif

  // Next phase and strobe decode from the current phase and opcode.
  always_comb begin
    w_state_nxt = r_state + 3'd1;
    o_sel_c     = 1'b0;
    o_rd_c      = 1'b0;
    o_ld_ir_c   = 1'b0;
    o_halt_c    = 1'b0;
    o_inc_pc_c  = 1'b0;
    o_ld_ac_c   = 1'b0;
    o_ld_pc_c   = 1'b0;
    o_wr_c      = 1'b0;
    o_data_e_c  = 1'b0;
`ifdef HALT_LATCH_EN
    w_halted_nxt = r_halted;
`endif
    case (r_state)
      S_INST_ADDR: o_sel_c = 1'b1;
      S_INST_FETCH: begin
        o_sel_c = 1'b1;
        o_rd_c  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        o_sel_c   = 1'b1;
        o_rd_c    = 1'b1;
        o_ld_ir_c = 1'b1;
      end
      S_OP_ADDR: begin
`ifdef HALT_LATCH_EN
        if (r_halted || w_hlt) begin
          o_halt_c     = 1'b1;
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_OP_ADDR;
        end else begin
          o_inc_pc_c = 1'b1;
        end
`else
        o_halt_c   = w_hlt;
        o_inc_pc_c = 1'b1;
`endif
      end
      S_OP_FETCH: o_rd_c = w_aluop;
      S_ALU_OP: begin
        o_rd_c     = w_aluop;
        o_inc_pc_c = w_skip;
        o_ld_pc_c  = w_jmp;
        o_data_e_c = w_sto;
      end
      S_STORE: begin
        o_rd_c     = w_aluop;
        o_ld_ac_c  = w_aluop;
        o_inc_pc_c = w_skip || w_jmp;
        o_ld_pc_c  = w_jmp;
        o_wr_c     = w_sto;
        o_data_e_c = w_sto;
      end
      default: w_state_nxt = S_INST_ADDR;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_path.sv
// RISC control path: address mux, ALU and zero detect around the phase sequencer.
// Optional macro HALT_LATCH_EN (see risc_phase_seq) makes HLT a sticky halt.
module risc_ctrl_path
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
)(
  input  logic            clk,
  input  logic            rst,
  risc_ctrl_path_if.slave bus
);

  logic [DATA_W-1:0] w_alu;
  logic [ADDR_W-1:0] w_addr;
  logic              w_zero;
  logic              w_sel;

  // Accumulator-side ALU; non-ALU opcodes pass the accumulator through.
  always_comb begin
    w_alu = bus.accum;
    case (bus.opcode)
      OP_ADD:  w_alu = DATA_W'(bus.accum + bus.data_in);
      OP_AND:  w_alu = bus.accum & bus.data_in;
      OP_XOR:  w_alu = bus.accum ^ bus.data_in;
      OP_LDA:  w_alu = bus.data_in;
      default: w_alu = bus.accum;
    endcase
  end

  assign w_zero = (bus.accum == '0);
  assign w_addr = w_sel ? bus.pc_addr : bus.op_addr;

  assign bus.alu_out  = w_alu;
  assign bus.is_zero  = w_zero;
  assign bus.addr_out = w_addr;
  assign bus.sel      = w_sel;

  risc_phase_seq u_seq (
    .clk        (clk),
    .rst        (rst),
    .i_opcode   (bus.opcode),
    .i_is_zero  (w_zero),
    .o_sel_c    (w_sel),
    .o_rd_c     (bus.rd),
    .o_ld_ir_c  (bus.ld_ir),
    .o_halt_c   (bus.halt),
    .o_inc_pc_c (bus.inc_pc),
    .o_ld_ac_c  (bus.ld_ac),
    .o_ld_pc_c  (bus.ld_pc),
    .o_wr_c     (bus.wr),
    .o_data_e_c (bus.data_e)
  );

endmodule

// File: tb/tb_risc_ctrl_path.sv
// Self-checking bench for risc_ctrl_path against a phase-count reference model.
module tb_risc_ctrl_path;
  import risc_pkg::*;

`ifdef HALT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  risc_ctrl_path_if bus ();

  risc_ctrl_path dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_phase = 0;
  bit m_halted = 1'b0;

  logic [8:0] strb;
  assign strb = {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
                 bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};

  // Expected strobes {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e} for a phase.
  function automatic logic [8:0] exp_strobes(int ph, logic [2:0] op, bit z, bit halted);
    bit aluop, skip, jmp, sto, frozen;
    bit sel, rd, ld_ir, halt, inc, ld_ac, ld_pc, wr, de;
    aluop  = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    skip   = (op == OP_SKZ) && z;
    jmp    = (op == OP_JMP);
    sto    = (op == OP_STO);
    frozen = LATCH && (ph == 4) && (halted || op == OP_HLT);
    sel    = (ph <= 3);
    rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    ld_ir  = (ph == 2 || ph == 3);
    halt   = (ph == 4) && (op == OP_HLT || halted);
    inc    = (ph == 4 && !frozen) || (ph == 6 && skip) || (ph == 7 && (skip || jmp));
    ld_ac  = (ph == 7) && aluop;
    ld_pc  = (ph == 6 || ph == 7) && jmp;
    wr     = (ph == 7) && sto;
    de     = (ph == 6 || ph == 7) && sto;
    return {sel, rd, ld_ir, halt, inc, ld_ac, ld_pc, wr, de};
  endfunction

  function automatic logic [7:0] exp_alu(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    int s;
    case (op)
      OP_ADD: begin s = (int'(a) + int'(b)) % 256; return 8'(s); end
      OP_AND: return a & b;
      OP_XOR: return a ^ b;
      OP_LDA: return b;
      default: return a;
    endcase
  endfunction

  // Advance one clock; the model follows the inputs present before the edge.
  task automatic tick();
    if (rst) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (LATCH && m_phase == 4 && (m_halted || bus.opcode == OP_HLT)) begin
      m_halted = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    bus.opcode = OP_ADD;
    bus.accum  = 8'h11;
    for (int i = 0; i < 5; i++) tick();
    bus.pc_addr = 5'h13;
    bus.op_addr = 5'h0C;
    do_reset();
    #1;
    e = 9'b1_0000_0000;
    n_cmp++;
    if (strb !== e) begin
      n_bad++;
      $display("FAIL reset_strobes got %b expected %b", strb, e);
    end
    n_cmp++;
    if (bus.addr_out !== 5'h13) begin
      n_bad++;
      $display("FAIL reset_addr got %h expected 13", bus.addr_out);
    end
  endtask

  task automatic test_seq_add();
    logic [8:0] e;
    do_reset();
    bus.opcode = OP_ADD;
    bus.accum  = 8'h03;
    for (int i = 0; i < 9; i++) begin
      #1;
      e = exp_strobes(i % 8, OP_ADD, 1'b0, 1'b0);
      n_cmp++;
      if (strb !== e) begin
        n_bad++;
        $display("FAIL seq_add ph=%0d got %b expected %b", i % 8, strb, e);
      end
      tick();
    end
  endtask

  task automatic test_alu_sweep();
    logic [2:0] ops [5];
    logic [7:0] res [5];
    logic [7:0] a, b, e;
    ops = '{OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO};
    res = '{8'h2C, 8'h30, 8'hCC, 8'h3C, 8'hF0};
    bus.accum   = 8'hF0;
    bus.data_in = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      bus.opcode = ops[i];
      #1;
      n_cmp++;
      if (bus.alu_out !== res[i]) begin
        n_bad++;
        $display("FAIL alu_dir op=%0d got %h expected %h", ops[i], bus.alu_out, res[i]);
      end
    end
    bus.accum = 8'h00;
    #1;
    n_cmp++;
    if (bus.is_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL is_zero got %b expected 1", bus.is_zero);
    end
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      bus.opcode  = 3'($urandom_range(0, 7));
      bus.accum   = a;
      bus.data_in = b;
      #1;
      e = exp_alu(bus.opcode, a, b);
      n_cmp++;
      if (bus.alu_out !== e || bus.is_zero !== (a == 8'h00)) begin
        n_bad++;
        $display("FAIL alu_rand op=%0d a=%h b=%h got %h/%b expected %h/%b",
                 bus.opcode, a, b, bus.alu_out, bus.is_zero, e, a == 8'h00);
      end
    end
  endtask

  // Runs eight phases from reset with a fixed opcode/accumulator.
  task automatic run_phases(string tag, logic [2:0] op, logic [7:0] acc);
    logic [8:0] e;
    do_reset();
    bus.opcode = op;
    bus.accum  = acc;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = exp_strobes(i, op, acc == 8'h00, 1'b0);
      n_cmp++;
      if (strb !== e) begin
        n_bad++;
        $display("FAIL %s ph=%0d got %b expected %b", tag, i, strb, e);
      end
      tick();
    end
  endtask

  task automatic test_skz();
    run_phases("skz_zero", OP_SKZ, 8'h00);
    run_phases("skz_nonzero", OP_SKZ, 8'h01);
  endtask

  task automatic test_sto_jmp();
    run_phases("sto", OP_STO, 8'h5A);
    run_phases("jmp", OP_JMP, 8'h5A);
  endtask

  task automatic test_halt();
    logic [8:0] e;
    int halts, want;
    do_reset();
    bus.opcode = OP_HLT;
    bus.accum  = 8'h07;
    halts = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      e = exp_strobes(m_phase, OP_HLT, 1'b0, m_halted);
      n_cmp++;
      if (strb !== e) begin
        n_bad++;
        $display("FAIL halt_seq cyc=%0d got %b expected %b", i, strb, e);
      end
      if (bus.halt === 1'b1) halts++;
      tick();
    end
    want = LATCH ? 12 : 2;
    n_cmp++;
    if (halts !== want) begin
      n_bad++;
      $display("FAIL halt_count got %0d expected %0d", halts, want);
    end
    do_reset();
    #1;
    n_cmp++;
    if (strb !== 9'b1_0000_0000) begin
      n_bad++;
      $display("FAIL halt_reset got %b expected 100000000", strb);
    end
  endtask

  task automatic test_addr_mux();
    logic [4:0] e;
    do_reset();
    bus.opcode  = OP_ADD;
    bus.pc_addr = 5'h1A;
    bus.op_addr = 5'h05;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = (i < 4) ? 5'h1A : 5'h05;
      n_cmp++;
      if (bus.addr_out !== e) begin
        n_bad++;
        $display("FAIL addr_mux ph=%0d got %h expected %h", i, bus.addr_out, e);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    logic [7:0] a, b;
    logic [4:0] pa, oa, ea;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      pa = 5'($urandom_range(0, 31));
      oa = 5'($urandom_range(0, 31));
      bus.opcode  = 3'($urandom_range(0, 7));
      bus.accum   = a;
      bus.data_in = b;
      bus.pc_addr = pa;
      bus.op_addr = oa;
      #1;
      e  = exp_strobes(m_phase, bus.opcode, a == 8'h00, m_halted);
      ea = (m_phase < 4) ? pa : oa;
      n_cmp++;
      if (strb !== e || bus.addr_out !== ea || bus.alu_out !== exp_alu(bus.opcode, a, b)) begin
        n_bad++;
        $display("FAIL random cyc=%0d ph=%0d op=%0d got %b/%h/%h expected %b/%h/%h",
                 i, m_phase, bus.opcode, strb, bus.addr_out, bus.alu_out,
                 e, ea, exp_alu(bus.opcode, a, b));
      end
      n_cmp++;
      if (bus.wr === 1'b1 && bus.rd === 1'b1) begin
        n_bad++;
        $display("FAIL rd_wr_overlap cyc=%0d got rd=1 wr=1 expected not both", i);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.opcode  = OP_HLT;
    bus.accum   = '0;
    bus.data_in = '0;
    bus.pc_addr = '0;
    bus.op_addr = '0;
    tick();
    rst = 1'b0;
    test_reset();
    test_seq_add();
    test_alu_sweep();
    test_skz();
    test_sto_jmp();
    test_halt();
    test_addr_mux();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
